// File: rtl/button_reset_conditioner.sv
// rtl/button_reset_conditioner.sv - button synchroniser/debouncer and CLK_CPU-aligned stretched CPU reset
module button_reset_conditioner #(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STRETCH_CYCLES  = 50000,
  parameter int CNT_W           = 20,
  parameter int STR_W           = 16
) (
  input  logic                   CLK_100MHz,
  input  logic                   RESET_N,
  input  logic                   CLK_CPU,
  input  logic [NUM_BUTTONS-1:0] BUT,
  output logic [NUM_BUTTONS-1:0] BUT_LEVEL,
  output logic [NUM_BUTTONS-1:0] BUT_PRESS,
  output logic [NUM_BUTTONS-1:0] BUT_RELEASE,
  output logic                   CPU_RESET
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_MAX = STR_W'(STRETCH_CYCLES);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    logic             sync1;
    logic             sync2;
    logic             s;
    logic             level;
    logic             commit;
    logic             prs_pulse;
    logic             rel_pulse;
    logic [CNT_W-1:0] cnt;

    // Pins idle high, so the synchroniser resets to 1 and no edge is seen on reset exit.
    assign s      = ~sync2;
    assign commit = (s != level) && (cnt == DB_LAST);

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
      if (!RESET_N) begin
        sync1     <= 1'b1;
        sync2     <= 1'b1;
        level     <= 1'b0;
        cnt       <= '0;
        prs_pulse <= 1'b0;
        rel_pulse <= 1'b0;
      end else begin
        sync1     <= BUT[i];
        sync2     <= sync1;
        prs_pulse <= commit && s;
        rel_pulse <= commit && !s;
        if ((s == level) || commit) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        if (commit) begin
          level <= s;
        end
      end
    end

    assign BUT_LEVEL[i]   = level;
    assign BUT_PRESS[i]   = prs_pulse;
    assign BUT_RELEASE[i] = rel_pulse;
  end

  typedef enum logic [1:0] {
    ST_POR,
    ST_RUN,
    ST_HELD,
    ST_STRETCH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [STR_W-1:0] str_cnt;
  logic [STR_W-1:0] str_cnt_nxt;
  logic             any_pressed;

  assign any_pressed = |BUT_LEVEL;

  always_comb begin
    state_nxt   = state;
    str_cnt_nxt = str_cnt;
    case (state)
      ST_POR, ST_STRETCH: begin
        if (any_pressed) begin
          state_nxt   = ST_HELD;
          str_cnt_nxt = '0;
        end else if (str_cnt == STR_MAX) begin
          // Leave reset only on a CPU enable so the CPU starts on an instruction boundary.
          if (CLK_CPU) begin
            state_nxt = ST_RUN;
          end
        end else begin
          str_cnt_nxt = str_cnt + STR_W'(1);
        end
      end
      ST_RUN: begin
        if (any_pressed) begin
          state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        str_cnt_nxt = '0;
        if (!any_pressed) begin
          state_nxt = ST_STRETCH;
        end
      end
      default: begin
        state_nxt   = ST_POR;
        str_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_POR;
      str_cnt   <= '0;
      CPU_RESET <= 1'b1;
    end else begin
      state     <= state_nxt;
      str_cnt   <= str_cnt_nxt;
      CPU_RESET <= (state_nxt != ST_RUN);
    end
  end

endmodule

// File: tb/tb_button_reset_conditioner.sv
// tb/tb_button_reset_conditioner.sv - directed self-checking bench for button_reset_conditioner
module tb_button_reset_conditioner;

  logic       clk;
  logic       rst_n;
  logic       clk_cpu;
  logic [1:0] but;
  logic [1:0] but_level;
  logic [1:0] but_press;
  logic [1:0] but_release;
  logic       cpu_reset;

  int   passed;
  int   failed;
  int   total;
  int   div;
  int   bad;
  int   drops;
  logic cpu_at_edge;

  button_reset_conditioner #(
    .NUM_BUTTONS    (2),
    .DEBOUNCE_CYCLES(8),
    .STRETCH_CYCLES (16),
    .CNT_W          (4),
    .STR_W          (5)
  ) dut (
    .CLK_100MHz (clk),
    .RESET_N    (rst_n),
    .CLK_CPU    (clk_cpu),
    .BUT        (but),
    .BUT_LEVEL  (but_level),
    .BUT_PRESS  (but_press),
    .BUT_RELEASE(but_release),
    .CPU_RESET  (cpu_reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; CLK_CPU strobes one cycle in five, updated just after the edge.
  task automatic tick();
    @(posedge clk);
    cpu_at_edge = clk_cpu;
    #1;
    div     = (div == 4) ? 0 : div + 1;
    clk_cpu = (div == 0);
    if (cpu_reset !== 1'b1) drops++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Expected fall: first edge at or after min_edges whose sampled CLK_CPU was high.
  task automatic run_stretch(input string tag, input int min_edges);
    int   m;
    int   exp_m;
    logic quiet;
    m     = 0;
    exp_m = -1;
    quiet = 1'b1;
    do begin
      tick();
      m++;
      if (exp_m < 0 && m >= min_edges && cpu_at_edge) exp_m = m;
      if (but_level != 2'b00 || but_press != 2'b00 || but_release != 2'b00) quiet = 1'b0;
    end while (cpu_reset === 1'b1 && m < 80);
    chk({tag, "_fall_edge"}, m, exp_m);
    chk({tag, "_quiet"}, quiet, 1);
  endtask

  initial begin
    passed  = 0;
    failed  = 0;
    total   = 0;
    div     = 0;
    drops   = 0;
    clk_cpu = 1'b0;
    rst_n   = 1'b0;
    but     = 2'b11;
    ticks(3);
    chk("rst_level", but_level, 2'b00);
    chk("rst_press", but_press, 2'b00);
    chk("rst_release", but_release, 2'b00);
    chk("rst_cpu_reset", cpu_reset, 1);

    rst_n = 1'b1;
    run_stretch("s1", 17);

    but = 2'b10;
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (but_level != 2'b00 || cpu_reset != 1'b0) bad++;
    end
    chk("s2_early", bad, 0);
    tick();
    chk("s2_level", but_level, 2'b01);
    chk("s2_press", but_press, 2'b01);
    chk("s2_cpu_still_run", cpu_reset, 0);
    tick();
    chk("s2_press_one_cycle", but_press, 2'b00);
    chk("s2_cpu_reset", cpu_reset, 1);

    bad   = 0;
    drops = 0;
    for (int k = 0; k < 43; k++) begin
      but[1] = ((k % 10) < 5 && k < 40) ? 1'b0 : 1'b1;
      tick();
      if (but_level != 2'b01 || but_press != 2'b00) bad++;
    end
    chk("s3_glitch_level_press", bad, 0);
    chk("s3_cpu_held", drops, 0);

    but = 2'b00;
    ticks(10);
    chk("s4_both_level", but_level, 2'b11);
    chk("s4_press1", but_press, 2'b10);
    but = 2'b01;
    ticks(10);
    chk("s4_rel0_level", but_level, 2'b10);
    chk("s4_rel0_pulse", but_release, 2'b01);
    ticks(10);
    but = 2'b11;
    ticks(10);
    chk("s4_rel1_level", but_level, 2'b00);
    chk("s4_rel1_pulse", but_release, 2'b10);
    chk("s4_cpu_held", drops, 0);
    run_stretch("s4", 18);

    but = 2'b10;
    ticks(10);
    chk("s5_level", but_level, 2'b01);
    but = 2'b11;
    tick();
    drops = 0;
    ticks(9);
    chk("s5_release", but_release, 2'b01);
    tick();
    but = 2'b10;
    ticks(10);
    chk("s5_repress_level", but_level, 2'b01);
    chk("s5_repress_pulse", but_press, 2'b01);
    but = 2'b11;
    ticks(10);
    chk("s5_final_release", but_level, 2'b00);
    chk("s5_no_drop", drops, 0);
    run_stretch("s5", 18);

    but = 2'b10;
    ticks(7);
    chk("s6_pre_run", cpu_reset, 0);
    rst_n = 1'b0;
    #2;
    chk("s6_async_cpu_reset", cpu_reset, 1);
    chk("s6_async_level", but_level, 2'b00);
    chk("s6_async_pulses", {but_press, but_release}, 4'b0000);
    but = 2'b11;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (but_press != 2'b00 || but_release != 2'b00 || cpu_reset != 1'b1) bad++;
    end
    chk("s6_in_reset", bad, 0);
    rst_n = 1'b1;
    run_stretch("s6", 17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_reset_conditioner.md
Name: button_reset_conditioner

Overview:
Upstream front-end for the Hack top level. It sits between the raw active-low BUT pins and the CPU reset and button inputs. It synchronises and debounces each button, produces clean active-high levels and one-cycle press/release pulses, and generates a stretched CPU_RESET. The CPU_RESET release is aligned to the CLK_CPU enable, so the CPU always leaves reset on a clean instruction boundary. This replaces the direct inverter-OR reset path.

Parameters:
NUM_BUTTONS, 2, number of button inputs.
DEBOUNCE_CYCLES, 1000000, consecutive stable CLK_100MHz cycles needed to accept a level change (10 ms).
STRETCH_CYCLES, 50000, minimum CPU_RESET hold after power-on or after the last button is released (0.5 ms).
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
STR_W, 16, stretch counter width; must satisfy 2^STR_W > STRETCH_CYCLES.

Ports:
CLK_100MHz  input  1  system clock; the only clock in the block.
RESET_N  input  1  reset, asynchronous assert, active-low.
CLK_CPU  input  1  one-cycle clock-enable strobe from the clock divider.
BUT  input  NUM_BUTTONS  raw button pins, active-low, asynchronous to the clock.
BUT_LEVEL  output  NUM_BUTTONS  debounced button state, 1 = pressed.
BUT_PRESS  output  NUM_BUTTONS  one-cycle pulse when a button's debounced level goes 0->1.
BUT_RELEASE  output  NUM_BUTTONS  one-cycle pulse when a button's debounced level goes 1->0.
CPU_RESET  output  1  active-high reset to the CPU, registered.

Behaviour:
Clocking and reset:
- Single clock domain. All state resets asynchronously while RESET_N=0.
- Values held during reset: sync flops=1 (idle high); BUT_LEVEL=0; BUT_PRESS=0; BUT_RELEASE=0; debounce counters=0; stretch counter=0; FSM=POR; CPU_RESET=1.

Per-button synchroniser and debouncer (one instance per button):
- Input path: 2-flop synchroniser, then inversion to active-high, giving s.
- While s != BUT_LEVEL, the counter increments each cycle.
- Any cycle with s == BUT_LEVEL clears the counter (bounce rejection).
- When the counter equals DEBOUNCE_CYCLES-1 and s != BUT_LEVEL, then on the next edge: BUT_LEVEL<=s, the counter clears, and PRESS or RELEASE pulses for exactly 1 cycle.
- Latency: a clean raw edge is reflected on BUT_LEVEL exactly DEBOUNCE_CYCLES+2 edges later. A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

Reset FSM. Define any = OR of BUT_LEVEL. CPU_RESET is registered and equals 1 whenever the next state != RUN.
- POR: the stretch counter increments and saturates at STRETCH_CYCLES. When saturated and CLK_CPU=1, go to RUN. If any=1, go to HELD.
- RUN: CPU_RESET=0. If any=1, go to HELD; CPU_RESET rises on the same edge as the BUT_LEVEL rise +1.
- HELD: CPU_RESET=1, stretch counter=0. If any=0, go to STRETCH.
- STRETCH: same counting and exit as POR. If any=1, go back to HELD and clear the counter.

Boundary cases:
- Simultaneous press of both buttons: both PRESS pulses fire in the same cycle; one HELD entry.
- Release of one button while the other is held: the FSM stays in HELD.
- CLK_CPU high on the cycle the counter saturates: exit to RUN happens on that edge.
- CLK_CPU low on that cycle: the FSM waits, with the counter held saturated, until the next CLK_CPU=1. Extra delay is bounded by the divider period.
- RESET_N asserted mid-debounce or mid-stretch: immediate return to the reset values; no pulses are emitted.
- Pulses are never emitted while RESET_N=0 or on the first edge after its release.

Test Plan:
(Bench settings: DEBOUNCE_CYCLES=8, STRETCH_CYCLES=16, CLK_CPU pulsing 1 cycle in 5.)
1. Release RESET_N with BUT=2'b11 -> CPU_RESET=1 for at least 16 cycles, then falls on the first edge with CLK_CPU=1. BUT_LEVEL=0 throughout; no pulses.
2. In RUN, drive BUT[0]=0 and hold -> BUT_LEVEL[0]=1 and BUT_PRESS[0]=1 for one cycle, exactly 10 edges after the drive. CPU_RESET=1 one edge later.
3. Toggle BUT[1] low for 5 cycles, then high, repeated 4 times -> BUT_LEVEL, PRESS and CPU_RESET unchanged.
4. Hold both buttons, release BUT[0], then 20 cycles later release BUT[1]:
   - CPU_RESET stays 1 until BUT_LEVEL[1] falls.
   - RELEASE pulses fire on the respective falling levels.
   - CPU_RESET falls at least 16 cycles after BUT_LEVEL[1]=0, aligned to CLK_CPU.
5. In STRETCH at count 10, re-press BUT[0] -> FSM returns to HELD, the count restarts, and CPU_RESET never drops.
6. Pull RESET_N low mid-debounce (counter=5) -> all outputs return to their reset values asynchronously within the same cycle; after release, behaviour matches scenario 1.
